// File: rtl/fan_pkg.sv
// Shared types and constants for the fan off-timer: FSM state encoding,
// the 16-bit BCD mm:ss time type and the preset-minute helpers.
package fan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN0,
    ST_RUN1,
    ST_RUN2,
    ST_EXPIRED
  } fan_state_t;

  // {min_tens, min_ones, sec_tens, sec_ones}
  typedef logic [15:0] bcd_time_t;

  localparam bcd_time_t TIME_ZERO = 16'h0000;
  localparam bcd_time_t TIME_ONE  = 16'h0001;

  localparam int unsigned DEFAULT_PRESET_MIN0 = 1;
  localparam int unsigned DEFAULT_PRESET_MIN1 = 3;
  localparam int unsigned DEFAULT_PRESET_MIN2 = 5;

  function automatic bcd_time_t min_to_bcd(input int unsigned minutes);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(minutes / 10);
    ones = 4'(minutes % 10);
    return {tens, ones, 8'h00};
  endfunction

  // True for 00:00 .. 00:10
  function automatic logic le_ten_sec(input bcd_time_t t);
    return (t[15:8] == 8'h00) && ((t[7:4] == 4'h0) || (t[7:0] == 8'h10));
  endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// Loadable BCD mm:ss down-counter with borrow chain and a 00:01 detect
// used by the FSM to recognise the final tick.
module bcd_mmss_down
  import fan_pkg::*;
(
  input  logic      clk,
  input  logic      reset_p,
  input  logic      i_load,
  input  bcd_time_t i_loadValue,
  input  logic      i_dec,
  output bcd_time_t o_value,
  output logic      o_isOne
);

  bcd_time_t r_value;
  bcd_time_t w_decValue;

  // Borrow ripples from seconds-ones upward; 00:00 holds rather than wrapping.
  always_comb begin
    w_decValue = r_value;
    if (r_value != TIME_ZERO) begin
      if (r_value[3:0] != 4'h0) begin
        w_decValue[3:0] = r_value[3:0] - 4'h1;
      end else begin
        w_decValue[3:0] = 4'h9;
        if (r_value[7:4] != 4'h0) begin
          w_decValue[7:4] = r_value[7:4] - 4'h1;
        end else begin
          w_decValue[7:4] = 4'h5;
          if (r_value[11:8] != 4'h0) begin
            w_decValue[11:8] = r_value[11:8] - 4'h1;
          end else begin
            w_decValue[11:8]  = 4'h9;
            w_decValue[15:12] = r_value[15:12] - 4'h1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_value <= TIME_ZERO;
    end else if (i_load) begin
      r_value <= i_loadValue;
    end else if (i_dec) begin
      r_value <= w_decValue;
    end
  end

  assign o_value = r_value;
  assign o_isOne = (r_value == TIME_ONE);

endmodule

// File: rtl/fan_off_timer.sv
// Fan off-timer: button cycles through three preset countdowns, stops the fan
// on expiry. Define FAN_OFF_TIMER_WARN_EN to build the final-10s blink output.
module fan_off_timer
  import fan_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned PRESET_MIN0 = DEFAULT_PRESET_MIN0,
  parameter int unsigned PRESET_MIN1 = DEFAULT_PRESET_MIN1,
  parameter int unsigned PRESET_MIN2 = DEFAULT_PRESET_MIN2
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        btn,
  output logic [15:0] value,
  output logic        timer_start,
  output logic        start_stop,
  output logic        expired,
  output logic        warn
);

  localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(CLK_HZ - 1);
  localparam bcd_time_t PRESET_BCD0 = min_to_bcd(PRESET_MIN0);
  localparam bcd_time_t PRESET_BCD1 = min_to_bcd(PRESET_MIN1);
  localparam bcd_time_t PRESET_BCD2 = min_to_bcd(PRESET_MIN2);

  fan_state_t         r_state;
  fan_state_t         w_nextState;
  logic [PRESC_W-1:0] r_presc;
  logic               r_timerStart;
  logic               r_startStop;
  logic               r_expired;
  logic               w_inRun;
  logic               w_tick;
  logic               w_load;
  bcd_time_t          w_loadValue;
  logic               w_dec;
  logic               w_expiring;
  bcd_time_t          w_value;
  logic               w_isOne;

  assign w_inRun = (r_state == ST_RUN0) || (r_state == ST_RUN1) || (r_state == ST_RUN2);
  assign w_tick  = w_inRun && (r_presc == PRESC_TERM);

  // A press always takes priority over a coincident tick, which is dropped.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_loadValue = TIME_ZERO;
    w_dec       = 1'b0;
    w_expiring  = 1'b0;
    if (btn) begin
      w_load = 1'b1;
      case (r_state)
        ST_IDLE: begin
          w_nextState = ST_RUN0;
          w_loadValue = PRESET_BCD0;
        end
        ST_RUN0: begin
          w_nextState = ST_RUN1;
          w_loadValue = PRESET_BCD1;
        end
        ST_RUN1: begin
          w_nextState = ST_RUN2;
          w_loadValue = PRESET_BCD2;
        end
        default: w_nextState = ST_IDLE;
      endcase
    end else if (w_tick) begin
      w_dec = 1'b1;
      if (w_isOne) begin
        w_expiring  = 1'b1;
        w_nextState = ST_EXPIRED;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state      <= ST_IDLE;
      r_presc      <= '0;
      r_timerStart <= 1'b0;
      r_startStop  <= 1'b0;
      r_expired    <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_presc      <= (btn || !w_inRun || w_tick) ? '0 : r_presc + 1'b1;
      r_timerStart <= (w_nextState != ST_IDLE);
      r_startStop  <= (w_nextState == ST_EXPIRED);
      r_expired    <= w_expiring;
    end
  end

  bcd_mmss_down u_counter (
    .clk        (clk),
    .reset_p    (reset_p),
    .i_load     (w_load),
    .i_loadValue(w_loadValue),
    .i_dec      (w_dec),
    .o_value    (w_value),
    .o_isOne    (w_isOne)
  );

`ifdef FAN_OFF_TIMER_WARN_EN
  localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(CLK_HZ / 2 - 1);
  logic r_warn;

  // Blink toggles on each half-second boundary during the last ten seconds.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_warn <= 1'b0;
    end else if (btn || !w_inRun || w_expiring || !le_ten_sec(w_value)) begin
      r_warn <= 1'b0;
    end else if ((r_presc == PRESC_HALF) || w_tick) begin
      r_warn <= ~r_warn;
    end
  end

  assign warn = r_warn;
`else
  assign warn = 1'b0;
`endif

  assign value       = w_value;
  assign timer_start = r_timerStart;
  assign start_stop  = r_startStop;
  assign expired     = r_expired;

endmodule

// File: tb/tb_fan_off_timer.sv
// Self-checking bench for fan_off_timer at CLK_HZ=10: seconds-level model
// checked every cycle plus directed literal checkpoints.
module tb_fan_off_timer;

  localparam int CLK_HZ = 10;
  localparam int PRE0   = 1;
  localparam int PRE1   = 3;
  localparam int PRE2   = 5;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        btn;
  logic [15:0] value;
  logic        timer_start;
  logic        start_stop;
  logic        expired;
  logic        warn;

  int total = 0;
  int bad = 0;
  int expCount = 0;
  bit checkOn = 1'b0;

  // Model: mode 0 idle, 1..3 run preset 0..2, 4 expired; time kept in seconds.
  int mMode;
  int mSec;
  int mCnt;
  bit mExp;
  bit mWarn;

  fan_off_timer #(
    .CLK_HZ     (CLK_HZ),
    .PRESET_MIN0(PRE0),
    .PRESET_MIN1(PRE1),
    .PRESET_MIN2(PRE2)
  ) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .btn        (btn),
    .value      (value),
    .timer_start(timer_start),
    .start_stop (start_stop),
    .expired    (expired),
    .warn       (warn)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] toBcd(input int s);
    int m;
    int ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic bit warnNext(input int sec, input bit cur, input bit boundary);
`ifdef FAN_OFF_TIMER_WARN_EN
    if (sec > 10) return 1'b0;
    return boundary ? !cur : cur;
`else
    return 1'b0;
`endif
  endfunction

  // Expected behaviour tracked per clock from the button/tick rules.
  always @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      mMode <= 0;
      mSec  <= 0;
      mCnt  <= 0;
      mExp  <= 1'b0;
      mWarn <= 1'b0;
    end else begin
      mExp <= 1'b0;
      if (btn) begin
        mCnt  <= 0;
        mWarn <= 1'b0;
        case (mMode)
          0: begin mMode <= 1; mSec <= PRE0 * 60; end
          1: begin mMode <= 2; mSec <= PRE1 * 60; end
          2: begin mMode <= 3; mSec <= PRE2 * 60; end
          default: begin mMode <= 0; mSec <= 0; end
        endcase
      end else if (mMode >= 1 && mMode <= 3) begin
        if (mCnt == CLK_HZ - 1) begin
          mCnt <= 0;
          if (mSec == 1) begin
            mSec  <= 0;
            mMode <= 4;
            mExp  <= 1'b1;
            mWarn <= 1'b0;
          end else begin
            mSec  <= mSec - 1;
            mWarn <= warnNext(mSec, mWarn, 1'b1);
          end
        end else begin
          mCnt  <= mCnt + 1;
          mWarn <= warnNext(mSec, mWarn, mCnt == CLK_HZ / 2 - 1);
        end
      end else begin
        mWarn <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn && !reset_p) begin
      checkOutput("model_value", value, toBcd(mSec));
      checkOutput("model_timer_start", {15'd0, timer_start}, {15'd0, mMode != 0});
      checkOutput("model_start_stop", {15'd0, start_stop}, {15'd0, mMode == 4});
      checkOutput("model_expired", {15'd0, expired}, {15'd0, mExp});
      checkOutput("model_warn", {15'd0, warn}, {15'd0, mWarn});
    end
  end

  always @(negedge clk) begin
    if (expired) expCount++;
  end

  task automatic applyStimulus();
    @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset_p = 1'b1;
    btn     = 1'b0;
    waitCycles(3);
    reset_p = 1'b0;
    checkOn = 1'b1;

    waitCycles(100);
    checkOutput("idle_value", value, 16'h0000);
    checkOutput("idle_timer_start", {15'd0, timer_start}, 16'h0000);
    checkOutput("idle_start_stop", {15'd0, start_stop}, 16'h0000);
    checkOutput("idle_warn", {15'd0, warn}, 16'h0000);

    // Full one-minute run to expiry.
    expCount = 0;
    applyStimulus();
    checkOutput("run0_load", value, 16'h0100);
    checkOutput("run0_timer_start", {15'd0, timer_start}, 16'h0001);
    waitCycles(10);
    checkOutput("first_tick", value, 16'h0059);
    waitCycles(490);
    checkOutput("ten_left", value, 16'h0010);
    checkOutput("ten_left_warn", {15'd0, warn}, 16'h0000);
    waitCycles(5);
`ifdef FAN_OFF_TIMER_WARN_EN
    checkOutput("warn_half", {15'd0, warn}, 16'h0001);
`else
    checkOutput("warn_half", {15'd0, warn}, 16'h0000);
`endif
    waitCycles(5);
    checkOutput("nine_left", value, 16'h0009);
    checkOutput("warn_full", {15'd0, warn}, 16'h0000);
    waitCycles(90);
    checkOutput("expiry_value", value, 16'h0000);
    checkOutput("expiry_start_stop", {15'd0, start_stop}, 16'h0001);
    checkOutput("expiry_pulse", {15'd0, expired}, 16'h0001);
    checkOutput("expiry_warn", {15'd0, warn}, 16'h0000);
    waitCycles(1);
    checkOutput("expiry_count", 16'(expCount), 16'd1);
    checkOutput("expiry_pulse_end", {15'd0, expired}, 16'h0000);
    applyStimulus();
    checkOutput("expired_btn_start_stop", {15'd0, start_stop}, 16'h0000);
    checkOutput("expired_btn_timer_start", {15'd0, timer_start}, 16'h0000);

    // Preset cycling and cancel.
    applyStimulus();
    checkOutput("cycle_run0", value, 16'h0100);
    applyStimulus();
    checkOutput("cycle_run1", value, 16'h0300);
    applyStimulus();
    checkOutput("cycle_run2", value, 16'h0500);
    applyStimulus();
    checkOutput("cancel_value", value, 16'h0000);
    checkOutput("cancel_timer_start", {15'd0, timer_start}, 16'h0000);

    // Press coinciding with the tick that would take 00:45 to 00:44.
    applyStimulus();
    waitCycles(159);
    checkOutput("at_0045", value, 16'h0045);
    applyStimulus();
    checkOutput("tick_discarded", value, 16'h0300);
    waitCycles(9);
    checkOutput("no_early_dec", value, 16'h0300);
    waitCycles(1);
    checkOutput("dec_after_load", value, 16'h0259);

    // Asynchronous reset mid-countdown.
    waitCycles(1420);
    checkOutput("at_0037", value, 16'h0037);
    #2 reset_p = 1'b1;
    #1;
    checkOutput("rst_value", value, 16'h0000);
    checkOutput("rst_timer_start", {15'd0, timer_start}, 16'h0000);
    checkOutput("rst_start_stop", {15'd0, start_stop}, 16'h0000);
    checkOutput("rst_expired", {15'd0, expired}, 16'h0000);
    checkOutput("rst_warn", {15'd0, warn}, 16'h0000);
    @(negedge clk);
    reset_p = 1'b0;
    applyStimulus();
    checkOutput("after_rst_run0", value, 16'h0100);
    checkOutput("after_rst_timer_start", {15'd0, timer_start}, 16'h0001);

    waitCycles(20);
    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
